// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions: default width, divider FSM states,
// and a conditional two's-complement negate helper.
package arith_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned NEG_W     = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  // Operates on a wide container; callers cast the result down to their own width,
  // which is exact because low bits of a negation depend only on low bits.
  function automatic logic [NEG_W-1:0] cond_negate(input logic [NEG_W-1:0] v,
                                                   input logic             neg);
    return neg ? (~v + NEG_W'(1)) : v;
  endfunction

endpackage

// File: rtl/seq_signed_divider_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
module div_restoring_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < dvs always holds, so the shifted value never reaches 2^WIDTH and the
  // borrow out of bit WIDTH is exactly the sign of the trial subtraction.
  always_comb begin
    shifted  = {rem, dvd_msb};
    trial    = shifted - {1'b0, dvs};
    q_bit    = ~trial[WIDTH];
    rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential truncating signed divider: restoring iteration on magnitudes,
// one quotient bit per enabled cycle, then a sign-fix cycle. start/done handshake.
module seq_signed_divider
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] dvd, dvd_n;
  logic [WIDTH-1:0] dvs, dvs_n;
  logic [WIDTH-1:0] rem, rem_n;
  logic [WIDTH-1:0] q, q_n;
  logic             sign_q, sign_q_n;
  logic             sign_r, sign_r_n;
  logic             dbz, dbz_n;
  logic             busy_n, done_n, div_by_zero_n;
  logic [WIDTH-1:0] quotient_n, remainder_n;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] abs_dividend, abs_divisor;

  div_restoring_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd_msb  (dvd[WIDTH-1]),
    .dvs      (dvs),
    .rem_next (step_rem),
    .q_bit    (step_qbit)
  );

  assign abs_dividend = WIDTH'(cond_negate(NEG_W'(dividend), dividend[WIDTH-1]));
  assign abs_divisor  = WIDTH'(cond_negate(NEG_W'(divisor),  divisor[WIDTH-1]));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      q           <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dbz         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (en) begin
      state       <= state_n;
      cnt         <= cnt_n;
      dvd         <= dvd_n;
      dvs         <= dvs_n;
      rem         <= rem_n;
      q           <= q_n;
      sign_q      <= sign_q_n;
      sign_r      <= sign_r_n;
      dbz         <= dbz_n;
      busy        <= busy_n;
      done        <= done_n;
      quotient    <= quotient_n;
      remainder   <= remainder_n;
      div_by_zero <= div_by_zero_n;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    dvd_n         = dvd;
    dvs_n         = dvs;
    rem_n         = rem;
    q_n           = q;
    sign_q_n      = sign_q;
    sign_r_n      = sign_r;
    dbz_n         = dbz;
    busy_n        = busy;
    done_n        = done;
    quotient_n    = quotient;
    remainder_n   = remainder;
    div_by_zero_n = div_by_zero;

    case (state)
      IDLE: begin
        done_n = 1'b0;
        if (start) begin
          sign_q_n = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          sign_r_n = dividend[WIDTH-1];
          dvd_n    = abs_dividend;
          dvs_n    = abs_divisor;
          rem_n    = '0;
          q_n      = '0;
          cnt_n    = CNT_W'(WIDTH);
          busy_n   = 1'b1;
          dbz_n    = (divisor == '0);
          state_n  = (divisor == '0) ? FIX : CALC;
        end
      end

      CALC: begin
        rem_n = step_rem;
        q_n   = {q[WIDTH-2:0], step_qbit};
        dvd_n = {dvd[WIDTH-2:0], 1'b0};
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_n = FIX;
      end

      FIX: begin
        // On divide-by-zero dvd was never shifted, so re-signing it restores the dividend.
        quotient_n    = dbz ? '1 : WIDTH'(cond_negate(NEG_W'(q), sign_q));
        remainder_n   = dbz ? WIDTH'(cond_negate(NEG_W'(dvd), sign_r))
                            : WIDTH'(cond_negate(NEG_W'(rem), sign_r));
        done_n        = 1'b1;
        busy_n        = 1'b0;
        div_by_zero_n = dbz;
        state_n       = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider: behavioural model plus directed literals.
module tb_seq_signed_divider;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset, en, start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  bit          cmp_on = 1'b0;

  seq_signed_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } res_t;

  function automatic res_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t   res;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    if (sb == 0) begin
      res.q = '1;
      res.r = a;
      res.z = 1'b1;
    end else begin
      res.q = W'(sa / sb);
      res.r = W'(sa % sb);
      res.z = 1'b0;
    end
    return res;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Behavioural model: a division completes after a fixed number of enabled edges.
  logic        m_busy, m_done;
  int unsigned m_left;
  res_t        m_out, m_pend;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
      m_out  <= '0;
      m_pend <= '0;
    end else if (en) begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_pend <= ref_div(dividend, divisor);
          m_busy <= 1'b1;
          m_left <= (divisor == '0) ? 1 : W + 1;
        end
      end else if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_out  <= m_pend;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("busy",        W'(busy),        W'(m_busy));
      chk("done",        W'(done),        W'(m_done));
      chk("quotient",    quotient,        m_out.q);
      chk("remainder",   remainder,       m_out.r);
      chk("div_by_zero", W'(div_by_zero), W'(m_out.z));
    end
  end

  task automatic go(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) chk({name, "_timeout"}, W'(done), W'(1));
  endtask

  task automatic chk_res(input string name, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ez);
    chk({name, "_q"}, quotient, eq);
    chk({name, "_r"}, remainder, er);
    chk({name, "_z"}, W'(div_by_zero), W'(ez));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return W'($urandom_range(0, 40)) - 32'd20;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int cyc;
    reset = 1'b1; en = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cmp_on = 1'b1;
    chk_res("rst", '0, '0, 1'b0);
    chk("rst_busy", W'(busy), '0);

    // 1: basic positive divide and latency
    go(32'd42, 32'd5);
    wait_done("t1", cyc);
    chk("t1_lat", W'(cyc), W'(33));
    chk_res("t1", 32'd8, 32'd2, 1'b0);

    // 2: sign combinations, back-to-back
    go(-32'sd547623, 32'd2);           wait_done("t2a", cyc);
    chk_res("t2a", -32'sd273811, -32'sd1, 1'b0);
    go(32'd7, -32'sd2);                wait_done("t2b", cyc);
    chk_res("t2b", -32'sd3, 32'd1, 1'b0);
    go(-32'sd7, -32'sd1);              wait_done("t2c", cyc);
    chk_res("t2c", 32'd7, 32'd0, 1'b0);

    // 3: divide by zero
    go(32'd100, 32'd0);                wait_done("t3", cyc);
    chk("t3_lat", W'(cyc), W'(1));
    chk_res("t3", 32'hFFFF_FFFF, 32'd100, 1'b1);

    // 4: overflow wrap and max positive
    go(32'h8000_0000, 32'hFFFF_FFFF);  wait_done("t4a", cyc);
    chk_res("t4a", 32'h8000_0000, 32'd0, 1'b0);
    go(32'h7FFF_FFFF, 32'd1);          wait_done("t4b", cyc);
    chk_res("t4b", 32'h7FFF_FFFF, 32'd0, 1'b0);

    // 5: start while busy ignored, then start in the done cycle
    go(32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    go(32'd9, 32'd3);
    wait_done("t5a", cyc);
    chk_res("t5a", 32'd142, 32'd6, 1'b0);
    go(32'd9, 32'd3);                  wait_done("t5b", cyc);
    chk("t5b_lat", W'(cyc), W'(33));
    chk_res("t5b", 32'd3, 32'd0, 1'b0);

    // 6: enable stall, then reset abort
    go(32'd1000, 32'd7);
    repeat (10) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    en = 1'b1;
    wait_done("t6a", cyc);
    chk("t6a_lat", W'(cyc + 15), W'(38));
    chk_res("t6a", 32'd142, 32'd6, 1'b0);
    @(negedge clk);
    go(32'd1000, 32'd7);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_res("t6b", '0, '0, 1'b0);
    chk("t6b_busy", W'(busy), '0);
    repeat (40) @(negedge clk);
    chk("t6b_nodone", W'(done), '0);
    go(32'd12, 32'd4);                 wait_done("t6c", cyc);
    chk_res("t6c", 32'd3, 32'd0, 1'b0);

    // Random operands with enable gaps and ignored starts while busy
    for (int i = 0; i < 40; i++) begin
      go(pick(), pick());
      cyc = 0;
      while (cyc < 300) begin
        @(negedge clk);
        cyc++;
        if (done === 1'b1) break;
        en       = ($urandom_range(0, 3) != 0);
        start    = ($urandom_range(0, 7) == 0);
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
      start = 1'b0;
      en    = 1'b1;
      if (done !== 1'b1) chk("rand_timeout", W'(done), W'(1));
    end

    repeat (3) @(negedge clk);
    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
